multi_axis_dda_executor: RTL and testbench
==========================================

// Module: multi_axis_dda_executor
// PURPOSE
//  Parametrised N-axis coordinated-move executor. Accepts move segments
//  (duration, per-axis dir/increment/increment-increment) into a DEPTH-entry
//  FIFO and runs each one through a clock-divided DDA that emits step/dir per
//  axis. Sits between the SPI command decoder and the per-axis motor drivers.
// PARAMETERS
//  AXES         3                     number of axes
//  DEPTH_BITS   2                     FIFO depth = 2**DEPTH_BITS entries
//  ACC_W        64                    signed accumulator/increment width
//  DUR_W        64                    move duration width (ticks)
//  DIV_W        8                     clock divisor width
//  STEP_THRESH  'h7fffffffffffff9b    per-step rollback constant (ACC_W bits)
// PORTS
//  CLK           in   1               system clock
//  resetn        in   1               reset
//  wr_valid      in   1               segment write request
//  wr_ready      out  1               FIFO can accept a segment
//  wr_duration   in   DUR_W           segment length D (segment runs D+1 ticks)
//  wr_dir        in   AXES            per-axis direction
//  wr_increment  in   AXES*ACC_W      per-axis initial increment (signed)
//  wr_incinc     in   AXES*ACC_W      per-axis per-tick increment delta (signed)
//  clock_divisor in   DIV_W           CLK cycles per tick = divisor+1
//  halt_n        in   1               active-low flush/stop
//  step          out  AXES            step level per axis (acc > 0)
//  dir           out  AXES            direction of the active/last segment
//  busy          out  1               state != IDLE
//  move_done     out  1               1-cycle pulse per completed segment
//  fill_level    out  DEPTH_BITS+1    stored segments, incl. the running one
// BEHAVIOUR
//  - Reset: resetn, synchronous, active-low; clock CLK. All outputs 0, fill 0,
//    accumulators 0, state IDLE. wr_ready goes to 1 on the first cycle after reset.
//  - Write: accepted when wr_valid & wr_ready. wr_ready = !halt & fill<2**DEPTH_BITS.
//    No full-bypass: a pop frees the slot on the following cycle.
//  - FSM IDLE->LOAD when fill>0. LOAD (1 cycle): head entry loads tickdown, inc_r[i]
//    and dir; clkaccum <= clock_divisor; ->RUN.
//  - RUN, every cycle: clkaccum decrements. On a tick (clkaccum==0): clkaccum reloads
//    from clock_divisor (sampled at reload); per axis acc += inc_r;
//    inc_r += incinc; tickdown decrements.
//  - Rollback, in every state: if acc[i]>0 (signed), acc[i] -= STEP_THRESH. Applied in
//    the same update as the tick add: acc <= acc + (tick?inc_r:0) - (acc>0?T:0).
//  - Segment end: a tick with tickdown==0 pops the head and pulses move_done the next
//    cycle. The FSM goes to LOAD if any entries remain after the pop, else to IDLE.
//  - Accumulators persist across segments and in IDLE, so the sub-step remainder
//    carries over. dir holds its last value while IDLE.
//  - Arithmetic wraps modulo 2**ACC_W with no saturation. Divisor 0 gives a tick
//    every RUN cycle.
//  - step[i] = (acc[i] > 0), driven combinationally from the registered acc.
//  - halt_n low (overrides all): FIFO pointers and fill go to 0, FSM to IDLE,
//    acc cleared, tickdown cleared. Writes are ignored and no move_done fires.
//  - resetn asserted mid-segment: same effect as reset, all state discarded.
// TESTING  (ACC_W=16, STEP_THRESH=100, AXES=3, DEPTH_BITS=2)
//  1. inc={0,-5,100}, incinc=0, div=1, D=3
//     -> step[0] gives 4 one-cycle pulses 2 cycles apart; step[1:2] stay 0;
//        one move_done.
//  2. inc0=0, incinc0=50, div=0, D=3
//     -> step[0] high exactly 3 consecutive cycles starting the cycle after the
//        2nd tick; acc0=0 afterwards.
//  3. Long segment running, 5 back-to-back writes
//     -> 4 accepted, fill=4, wr_ready=0. 5th accepted the cycle after the first
//        move_done+1.
//  4. halt_n low 1 cycle mid-segment
//     -> next cycle fill=0, busy=0, step=0, no move_done; a write during halt
//        is ignored.
//  5. resetn low mid-segment
//     -> all outputs 0; a fresh segment afterwards runs exactly as in test 1.
//  6. Two queued segments with dir 1 then 0
//     -> dir changes in the LOAD cycle between them; busy stays 1 throughout.

Source files
------------

// File: rtl/multi_axis_dda_executor.sv
// Multi-axis DDA move executor: queues move segments in a small FIFO and runs each one
// through a clock-divided digital differential analyser that produces per-axis step/dir.
module multi_axis_dda_executor #(
    parameter int               AXES        = 3,
    parameter int               DEPTH_BITS  = 2,
    parameter int               ACC_W       = 64,
    parameter int               DUR_W       = 64,
    parameter int               DIV_W       = 8,
    parameter logic [ACC_W-1:0] STEP_THRESH = ACC_W'(64'h7fff_ffff_ffff_ff9b)
) (
    input  logic                  CLK,
    input  logic                  resetn,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DUR_W-1:0]      wr_duration,
    input  logic [AXES-1:0]       wr_dir,
    input  logic [AXES*ACC_W-1:0] wr_increment,
    input  logic [AXES*ACC_W-1:0] wr_incinc,
    input  logic [DIV_W-1:0]      clock_divisor,
    input  logic                  halt_n,
    output logic [AXES-1:0]       step,
    output logic [AXES-1:0]       dir,
    output logic                  busy,
    output logic                  move_done,
    output logic [DEPTH_BITS:0]   fill_level
);
    localparam int                  DEPTH      = 2 ** DEPTH_BITS;
    localparam logic [DEPTH_BITS:0] DEPTH_FULL = (DEPTH_BITS+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
    typedef logic [AXES-1:0][ACC_W-1:0] axis_vec_t;

    state_t                state_q, state_d;

    logic [DUR_W-1:0]      dur_mem    [DEPTH];
    logic [AXES-1:0]       dir_mem    [DEPTH];
    axis_vec_t             inc_mem    [DEPTH];
    axis_vec_t             incinc_mem [DEPTH];

    logic [DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_BITS:0]   fill_q, fill_d;
    logic [DUR_W-1:0]      tickdown_q, tickdown_d;
    logic [DIV_W-1:0]      clkaccum_q, clkaccum_d;
    axis_vec_t             inc_q, inc_d;
    axis_vec_t             acc_q, acc_d;
    logic [AXES-1:0]       dir_q, dir_d;
    logic                  move_done_q, move_done_d;

    logic                  halt;
    logic                  push;
    logic                  pop;
    logic                  tick;
    logic                  seg_end;
    logic                  load_en;
    logic                  run_en;
    logic [AXES-1:0]       acc_pos;
    axis_vec_t             head_inc;
    axis_vec_t             head_incinc;

    assign halt        = ~halt_n;
    assign wr_ready    = resetn & halt_n & (fill_q < DEPTH_FULL);
    assign push        = wr_valid & wr_ready;
    assign tick        = run_en & (clkaccum_q == '0);
    assign seg_end     = tick & (tickdown_q == '0);
    assign pop         = seg_end & ~halt;
    assign head_inc    = inc_mem[rd_ptr_q];
    assign head_incinc = incinc_mem[rd_ptr_q];

    // ---------------- FSM: state register ----------------
    always_ff @(posedge CLK) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    // NOTE: every variable written in a combinational block gets a default first,
    // so no path through the block leaves it unassigned and infers a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (fill_q != '0) state_d = LOAD;
            LOAD:    state_d = RUN;
            RUN:     if (seg_end) state_d = (fill_d != '0) ? LOAD : IDLE;
            default: state_d = IDLE;
        endcase
        if (halt) begin
            state_d = IDLE;
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        load_en = 1'b0;
        run_en  = 1'b0;
        busy    = 1'b1;
        unique case (state_q)
            IDLE:    busy    = 1'b0;
            LOAD:    load_en = 1'b1;
            RUN:     run_en  = 1'b1;
            default: busy    = 1'b0;
        endcase
    end

    // ---------------- FIFO bookkeeping ----------------
    always_comb begin
        wr_ptr_d = wr_ptr_q + DEPTH_BITS'(push);
        rd_ptr_d = rd_ptr_q + DEPTH_BITS'(pop);
        fill_d   = fill_q + (DEPTH_BITS+1)'(push) - (DEPTH_BITS+1)'(pop);
        if (halt) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            fill_d   = '0;
        end
    end

    // NOTE: the segment storage carries no reset; every entry is written before the
    // fill count lets it be read, so clearing it would only cost reset fan-out.
    always_ff @(posedge CLK) begin
        if (push) begin
            dur_mem[wr_ptr_q]    <= wr_duration;
            dir_mem[wr_ptr_q]    <= wr_dir;
            inc_mem[wr_ptr_q]    <= wr_increment;
            incinc_mem[wr_ptr_q] <= wr_incinc;
        end
    end

    // ---------------- DDA datapath ----------------
    always_comb begin
        for (int i = 0; i < AXES; i++) begin
            acc_pos[i] = ~acc_q[i][ACC_W-1] & (|acc_q[i]);
        end
    end

    always_comb begin
        clkaccum_d  = clkaccum_q;
        tickdown_d  = tickdown_q;
        inc_d       = inc_q;
        dir_d       = dir_q;
        acc_d       = acc_q;
        move_done_d = pop;

        if (load_en) begin
            tickdown_d = dur_mem[rd_ptr_q];
            inc_d      = head_inc;
            dir_d      = dir_mem[rd_ptr_q];
            clkaccum_d = clock_divisor;
        end else if (run_en) begin
            if (tick) begin
                clkaccum_d = clock_divisor;
                tickdown_d = tickdown_q - DUR_W'(1);
            end else begin
                clkaccum_d = clkaccum_q - DIV_W'(1);
            end
        end

        // Rollback runs in every state so a leftover positive remainder drains even when idle.
        for (int i = 0; i < AXES; i++) begin
            acc_d[i] = acc_q[i] + (tick ? inc_q[i] : '0) - (acc_pos[i] ? STEP_THRESH : '0);
            if (tick) begin
                inc_d[i] = inc_q[i] + head_incinc[i];
            end
        end

        if (halt) begin
            acc_d       = '0;
            tickdown_d  = '0;
            move_done_d = 1'b0;
        end
    end

    // NOTE: all state registers update with non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (!resetn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fill_q      <= '0;
            tickdown_q  <= '0;
            clkaccum_q  <= '0;
            inc_q       <= '0;
            acc_q       <= '0;
            dir_q       <= '0;
            move_done_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fill_q      <= fill_d;
            tickdown_q  <= tickdown_d;
            clkaccum_q  <= clkaccum_d;
            inc_q       <= inc_d;
            acc_q       <= acc_d;
            dir_q       <= dir_d;
            move_done_q <= move_done_d;
        end
    end

    assign step       = acc_pos;
    assign dir        = dir_q;
    assign move_done  = move_done_q;
    assign fill_level = fill_q;

endmodule

// File: tb/tb_multi_axis_dda_executor.sv
// Scoreboard bench for multi_axis_dda_executor: each queued segment pushes its expected
// step signature; a monitor compares it against the observed steps at every move_done.
module tb_multi_axis_dda_executor;
    localparam int AXES       = 3;
    localparam int DEPTH_BITS = 2;
    localparam int ACC_W      = 16;
    localparam int DUR_W      = 16;
    localparam int DIV_W      = 8;

    typedef logic [AXES-1:0][ACC_W-1:0] axis_vec_t;

    typedef struct {
        int              rises0;
        int              high0;
        int              gap0;
        int              high12;
        logic [AXES-1:0] dir;
    } exp_t;

    logic                CLK;
    logic                resetn;
    logic                wr_valid;
    logic                wr_ready;
    logic [DUR_W-1:0]    wr_duration;
    logic [AXES-1:0]     wr_dir;
    axis_vec_t           wr_increment;
    axis_vec_t           wr_incinc;
    logic [DIV_W-1:0]    clock_divisor;
    logic                halt_n;
    logic [AXES-1:0]     step;
    logic [AXES-1:0]     dir;
    logic                busy;
    logic                move_done;
    logic [DEPTH_BITS:0] fill_level;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    multi_axis_dda_executor #(
        .AXES(AXES), .DEPTH_BITS(DEPTH_BITS), .ACC_W(ACC_W), .DUR_W(DUR_W),
        .DIV_W(DIV_W), .STEP_THRESH(16'd100)
    ) dut (
        .CLK(CLK), .resetn(resetn), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_duration(wr_duration), .wr_dir(wr_dir), .wr_increment(wr_increment),
        .wr_incinc(wr_incinc), .clock_divisor(clock_divisor), .halt_n(halt_n),
        .step(step), .dir(dir), .busy(busy), .move_done(move_done),
        .fill_level(fill_level)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no summary, required finish within 1ms");
        $fatal(1);
    end

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    function automatic axis_vec_t vec(input int a0, input int a1, input int a2);
        axis_vec_t v;
        v[0] = ACC_W'(a0);
        v[1] = ACC_W'(a1);
        v[2] = ACC_W'(a2);
        return v;
    endfunction

    function automatic exp_t mk_exp(input int r, input int h, input int g, input int h12,
                                    input logic [AXES-1:0] d);
        exp_t e;
        e.rises0 = r;
        e.high0  = h;
        e.gap0   = g;
        e.high12 = h12;
        e.dir    = d;
        return e;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    int   m_cycle     = 0;
    int   m_rises0    = 0;
    int   m_high0     = 0;
    int   m_high12    = 0;
    int   m_min_gap   = 0;
    int   m_max_gap   = 0;
    int   m_last_rise = 0;
    logic m_prev0     = 1'b0;

    always @(negedge CLK) begin
        m_cycle++;
        if (!resetn || !halt_n) begin
            m_rises0  = 0;
            m_high0   = 0;
            m_high12  = 0;
            m_min_gap = 0;
            m_max_gap = 0;
            m_prev0   = 1'b0;
        end else begin
            if (step[0]) begin
                m_high0++;
                if (!m_prev0) begin
                    int gap;
                    gap = m_cycle - m_last_rise;
                    if (m_rises0 == 1) begin
                        m_min_gap = gap;
                        m_max_gap = gap;
                    end else if (m_rises0 > 1) begin
                        if (gap < m_min_gap) m_min_gap = gap;
                        if (gap > m_max_gap) m_max_gap = gap;
                    end
                    m_rises0++;
                    m_last_rise = m_cycle;
                end
            end
            m_high12 += int'(step[1]) + int'(step[2]);
            m_prev0 = step[0];
            if (move_done) begin
                check("done_has_expectation", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("seg_rises0", m_rises0, e.rises0);
                    check("seg_high0", m_high0, e.high0);
                    check("seg_gap0_min", m_min_gap, e.gap0);
                    check("seg_gap0_max", m_max_gap, e.gap0);
                    check("seg_high12", m_high12, e.high12);
                    check("seg_dir", dir, e.dir);
                end
                m_rises0  = 0;
                m_high0   = 0;
                m_high12  = 0;
                m_min_gap = 0;
                m_max_gap = 0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic write_seg(input logic [DUR_W-1:0] dur, input logic [AXES-1:0] d,
                             input axis_vec_t inc, input axis_vec_t incinc,
                             input bit track, input exp_t e);
        int waited;
        waited       = 0;
        wr_duration  = dur;
        wr_dir       = d;
        wr_increment = inc;
        wr_incinc    = incinc;
        wr_valid     = 1'b1;
        @(negedge CLK);
        while (!wr_ready && waited < 200) begin
            waited++;
            @(negedge CLK);
        end
        check("write_ready", wr_ready, 1);
        if (wr_ready && track) exp_q.push_back(e);
        next_cycle();
        wr_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        @(negedge CLK);
        while ((busy || fill_level != 0 || exp_q.size() != 0) && n < 500) begin
            n++;
            @(negedge CLK);
        end
        check({"idle_", tag}, longint'(busy || fill_level != 0 || exp_q.size() != 0), 0);
        repeat (3) @(negedge CLK);
        next_cycle();
    endtask

    // ---------------- directed tests ----------------
    initial begin
        axis_vec_t zero;
        int        n;
        int        dones;
        int        not_busy;
        bit        accepted;
        bit        dir_checked;

        zero          = '0;
        resetn        = 1'b0;
        halt_n        = 1'b1;
        wr_valid      = 1'b0;
        wr_duration   = '0;
        wr_dir        = '0;
        wr_increment  = '0;
        wr_incinc     = '0;
        clock_divisor = '0;

        repeat (3) @(negedge CLK);
        check("rst_wr_ready", wr_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_fill", fill_level, 0);
        check("rst_step", step, 0);
        check("rst_dir", dir, 0);
        check("rst_move_done", move_done, 0);
        next_cycle();
        resetn = 1'b1;
        @(negedge CLK);
        check("ready_after_reset", wr_ready, 1);
        next_cycle();

        // Test 1: axis0 +100 per tick, axis1 -5, divisor 1 -> four pulses two cycles apart
        clock_divisor = 8'd1;
        write_seg(3, 3'b010, vec(100, -5, 0), zero, 1'b1, mk_exp(4, 4, 2, 0, 3'b010));
        wait_idle("t1");

        // Test 2: ramp of 50 per tick from 0 -> acc0 = 0,50,50,100 then drains to 0
        clock_divisor = 8'd0;
        write_seg(3, 3'b001, zero, vec(50, 0, 0), 1'b1, mk_exp(1, 3, 0, 0, 3'b001));
        wait_idle("t2");
        @(negedge CLK);
        check("t2_step_settled", step, 0);
        next_cycle();

        // Test 3: long segment plus three short ones fill the FIFO; the fifth waits
        write_seg(20, 3'b100, zero, zero, 1'b1, mk_exp(0, 0, 0, 0, 3'b100));
        write_seg(0, 3'b011, vec(100, 0, 0), zero, 1'b1, mk_exp(1, 1, 0, 0, 3'b011));
        write_seg(0, 3'b110, vec(100, 0, 0), zero, 1'b1, mk_exp(1, 1, 0, 0, 3'b110));
        write_seg(0, 3'b101, vec(100, 0, 0), zero, 1'b1, mk_exp(1, 1, 0, 0, 3'b101));
        wr_duration  = '0;
        wr_dir       = 3'b001;
        wr_increment = vec(100, 0, 0);
        wr_incinc    = zero;
        wr_valid     = 1'b1;
        @(negedge CLK);
        check("t3_fill_full", fill_level, 4);
        check("t3_ready_low_full", wr_ready, 0);
        n        = 0;
        accepted = 1'b0;
        while (!accepted && n < 200) begin
            if (wr_ready) begin
                accepted = 1'b1;
                check("t3_accept_with_done", move_done, 1);
                check("t3_fill_after_pop", fill_level, 3);
                exp_q.push_back(mk_exp(1, 1, 0, 0, 3'b001));
            end else begin
                n++;
                @(negedge CLK);
            end
        end
        check("t3_fifth_accepted", accepted, 1);
        next_cycle();
        wr_valid = 1'b0;
        wait_idle("t3");

        // Test 4: one-cycle halt mid-segment with a write presented during it
        clock_divisor = 8'd1;
        write_seg(10, 3'b010, vec(100, 0, 0), zero, 1'b0, mk_exp(0, 0, 0, 0, 3'b000));
        repeat (8) next_cycle();
        @(negedge CLK);
        check("t4_busy_before_halt", busy, 1);
        next_cycle();
        halt_n       = 1'b0;
        wr_valid     = 1'b1;
        wr_duration  = 16'd5;
        wr_dir       = 3'b111;
        wr_increment = vec(100, 0, 0);
        @(negedge CLK);
        check("t4_ready_low_in_halt", wr_ready, 0);
        next_cycle();
        halt_n   = 1'b1;
        wr_valid = 1'b0;
        @(negedge CLK);
        check("t4_fill_cleared", fill_level, 0);
        check("t4_busy_cleared", busy, 0);
        check("t4_step_cleared", step, 0);
        check("t4_no_move_done", move_done, 0);
        next_cycle();
        @(negedge CLK);
        check("t4_write_ignored", fill_level, 0);
        check("t4_still_idle", busy, 0);
        next_cycle();
        wait_idle("t4");

        // Test 5: reset mid-segment, then a fresh copy of test 1
        write_seg(10, 3'b101, vec(100, 0, 0), zero, 1'b0, mk_exp(0, 0, 0, 0, 3'b000));
        repeat (7) next_cycle();
        resetn = 1'b0;
        next_cycle();
        @(negedge CLK);
        check("t5_step", step, 0);
        check("t5_dir", dir, 0);
        check("t5_busy", busy, 0);
        check("t5_move_done", move_done, 0);
        check("t5_fill", fill_level, 0);
        check("t5_wr_ready", wr_ready, 0);
        next_cycle();
        resetn = 1'b1;
        @(negedge CLK);
        check("t5_ready_after_reset", wr_ready, 1);
        next_cycle();
        write_seg(3, 3'b010, vec(100, -5, 0), zero, 1'b1, mk_exp(4, 4, 2, 0, 3'b010));
        wait_idle("t5");

        // Test 6: two queued segments with opposite directions
        clock_divisor = 8'd0;
        write_seg(2, 3'b111, zero, zero, 1'b1, mk_exp(0, 0, 0, 0, 3'b111));
        write_seg(2, 3'b000, zero, zero, 1'b1, mk_exp(0, 0, 0, 0, 3'b000));
        dones       = 0;
        not_busy    = 0;
        n           = 0;
        dir_checked = 1'b0;
        while (dones < 2 && n < 100) begin
            @(negedge CLK);
            n++;
            if (dones == 1 && !dir_checked) begin
                check("t6_dir_after_load", dir, 0);
                dir_checked = 1'b1;
            end
            if (move_done) dones++;
            if (dones < 2 && !busy) not_busy++;
        end
        check("t6_two_dones", dones, 2);
        check("t6_busy_gaps", not_busy, 0);
        next_cycle();
        wait_idle("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
